// File: rtl/sync_fifo_if.sv
// Handshake bundle between a producer/consumer pair and sync_fifo.
// The FIFO connects through the slave modport; the side that pushes and
// pops words connects through the master modport.
interface sync_fifo_if #(
   parameter int Width = 12,
   parameter int Depth = 8
);
   localparam int CW = $clog2(Depth + 1);

   logic             flush;
   logic             w;
   logic [Width-1:0] wd;
   logic             wfull;
   logic             walmostfull;
   logic             r;
   logic [Width-1:0] rd;
   logic             rempty;
   logic             ralmostempty;
   logic [CW-1:0]    count;
   logic             overflow;
   logic             underflow;

   modport master (
      output flush, w, wd, r,
      input  wfull, walmostfull, rd, rempty, ralmostempty, count, overflow, underflow
   );

   modport slave (
      input  flush, w, wd, r,
      output wfull, walmostfull, rd, rempty, ralmostempty, count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with fill level, almost-full /
// almost-empty thresholds, synchronous flush and sticky error flags.
// Depth may be any integer >= 2; pointers wrap explicitly at Depth-1.
// The head word is presented on rd one edge after it was written, so rd is
// always loaded from storage that was written at an earlier edge.
module sync_fifo #(
   parameter int Width            = 12,
   parameter int Depth            = 8,
   parameter int AlmostFullLevel  = Depth - 2,
   parameter int AlmostEmptyLevel = 1
) (
   input  logic     clk,
   input  logic     rst,
   sync_fifo_if.slave bus
);
   localparam int CW = $clog2(Depth + 1);
   localparam int PW = $clog2(Depth);

   localparam logic [CW-1:0] FULL_LVL  = CW'(Depth);
   localparam logic [CW-1:0] AF_LVL    = CW'(AlmostFullLevel);
   localparam logic [CW-1:0] AE_LVL    = CW'(AlmostEmptyLevel);
   localparam logic [PW-1:0] LAST_PTR  = PW'(Depth - 1);
   localparam logic          AF_AT_RST = (AlmostFullLevel == 0);

   // Storage; no reset so it maps onto block RAM.
   logic [Width-1:0] r_mem [Depth];

   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic [Width-1:0] r_rd;
   logic             r_rempty;
   logic             r_wfull;
   logic             r_walmostfull;
   logic             r_ralmostempty;
   logic             r_overflow;
   logic             r_underflow;

   logic             w_wok;
   logic             w_rok;
   logic [PW-1:0]    w_wptr_next;
   logic [PW-1:0]    w_rptr_next;
   logic [CW-1:0]    w_count_next;
   logic             w_head_new;
   logic             w_rempty_next;
   logic             w_load_rd;

   // Accept decisions, next pointers/count, and head visibility for the next cycle.
   always_comb begin
      w_wok = bus.w & ~r_wfull & ~bus.flush;
      w_rok = bus.r & ~r_rempty & ~bus.flush;

      w_wptr_next = r_wptr;
      if (w_wok) begin
         w_wptr_next = (r_wptr == LAST_PTR) ? '0 : r_wptr + 1'b1;
      end

      w_rptr_next = r_rptr;
      if (w_rok) begin
         w_rptr_next = (r_rptr == LAST_PTR) ? '0 : r_rptr + 1'b1;
      end

      case ({w_wok, w_rok})
         2'b10:   w_count_next = r_count + 1'b1;
         2'b01:   w_count_next = r_count - 1'b1;
         default: w_count_next = r_count;
      endcase

      // The word written on this edge becomes the head when nothing else remains
      // ahead of it; it is not yet readable from storage, so the output stays empty.
      w_head_new    = w_wok & ((r_count == '0) | (w_rok & (r_count == CW'(1))));
      w_rempty_next = (w_count_next == '0) | w_head_new;

      // Reload rd only when a word will be visible and the current one is consumed
      // or was not visible; otherwise rd holds (last word, or 0 after reset/flush).
      w_load_rd = ~w_rempty_next & (w_rok | r_rempty);
   end

   // Write port of the storage array.
   always_ff @(posedge clk) begin
      if (w_wok) begin
         r_mem[r_wptr] <= bus.wd;
      end
   end

   // Control state, registered output word and status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr         <= '0;
         r_rptr         <= '0;
         r_count        <= '0;
         r_rd           <= '0;
         r_rempty       <= 1'b1;
         r_wfull        <= 1'b0;
         r_walmostfull  <= AF_AT_RST;
         r_ralmostempty <= 1'b1;
         r_overflow     <= 1'b0;
         r_underflow    <= 1'b0;
      end else if (bus.flush) begin
         r_wptr         <= '0;
         r_rptr         <= '0;
         r_count        <= '0;
         r_rd           <= '0;
         r_rempty       <= 1'b1;
         r_wfull        <= 1'b0;
         r_walmostfull  <= AF_AT_RST;
         r_ralmostempty <= 1'b1;
         r_overflow     <= 1'b0;
         r_underflow    <= 1'b0;
      end else begin
         r_wptr         <= w_wptr_next;
         r_rptr         <= w_rptr_next;
         r_count        <= w_count_next;
         r_rempty       <= w_rempty_next;
         r_wfull        <= (w_count_next == FULL_LVL);
         r_walmostfull  <= (w_count_next >= AF_LVL);
         r_ralmostempty <= (w_count_next <= AE_LVL);
         r_overflow     <= r_overflow | (bus.w & r_wfull);
         r_underflow    <= r_underflow | (bus.r & r_rempty);
         if (w_load_rd) begin
            r_rd <= r_mem[w_rptr_next];
         end
      end
   end

   assign bus.rd           = r_rd;
   assign bus.rempty       = r_rempty;
   assign bus.wfull        = r_wfull;
   assign bus.walmostfull  = r_walmostfull;
   assign bus.ralmostempty = r_ralmostempty;
   assign bus.count        = r_count;
   assign bus.overflow     = r_overflow;
   assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: an 8-deep and a 6-deep instance share one
// set of stimulus variables, steered by sel. Status is compared as a packed
// vector {count, rempty, wfull, walmostfull, ralmostempty, overflow, underflow}.
module tb_sync_fifo;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tw = 1'b0;
   logic        tr = 1'b0;
   logic        tflush = 1'b0;
   logic        tsel = 1'b0;
   logic [11:0] twd = '0;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   sync_fifo_if #(.Width(12), .Depth(8)) bus8 ();
   sync_fifo_if #(.Width(12), .Depth(6)) bus6 ();

   sync_fifo #(.Width(12), .Depth(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
   sync_fifo #(.Width(12), .Depth(6)) u_dut6 (.clk(clk), .rst(rst), .bus(bus6));

   assign bus8.flush = tflush & ~tsel;
   assign bus8.w     = tw & ~tsel;
   assign bus8.r     = tr & ~tsel;
   assign bus8.wd    = twd;
   assign bus6.flush = tflush & tsel;
   assign bus6.w     = tw & tsel;
   assign bus6.r     = tr & tsel;
   assign bus6.wd    = twd;

   logic [9:0]  st;
   logic [11:0] rdv;
   assign st = tsel ? {1'b0, bus6.count, bus6.rempty, bus6.wfull, bus6.walmostfull,
                       bus6.ralmostempty, bus6.overflow, bus6.underflow}
                    : {bus8.count, bus8.rempty, bus8.wfull, bus8.walmostfull,
                       bus8.ralmostempty, bus8.overflow, bus8.underflow};
   assign rdv = tsel ? bus6.rd : bus8.rd;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      repeat (5) tick();
      n_checks++;
      if ({st, rdv} !== {4'd0, 6'b100100, 12'h000})
         $display("FAIL reset_d8: got %h expected %h", {st, rdv}, {4'd0, 6'b100100, 12'h000});
      else n_pass++;
      tsel = 1'b1;
      #1;
      n_checks++;
      if ({st, rdv} !== {4'd0, 6'b100100, 12'h000})
         $display("FAIL reset_d6: got %h expected %h", {st, rdv}, {4'd0, 6'b100100, 12'h000});
      else n_pass++;
      tsel = 1'b0;
      #1;
      $display("test_reset: done");
   endtask

   task automatic test_single_write;
      tw = 1'b1; twd = 12'h001;
      tick();
      tw = 1'b0;
      n_checks++;
      if (st !== {4'd1, 6'b100100})
         $display("FAIL single_hidden: got %h expected %h", st, {4'd1, 6'b100100});
      else n_pass++;
      tick();
      n_checks++;
      if ({st, rdv} !== {4'd1, 6'b000100, 12'h001})
         $display("FAIL single_visible: got %h expected %h", {st, rdv}, {4'd1, 6'b000100, 12'h001});
      else n_pass++;
      tr = 1'b1;
      tick();
      tr = 1'b0;
      n_checks++;
      if ({st, rdv} !== {4'd0, 6'b100100, 12'h001})
         $display("FAIL single_read: got %h expected %h", {st, rdv}, {4'd0, 6'b100100, 12'h001});
      else n_pass++;
      $display("test_single_write: done");
   endtask

   task automatic test_fill;
      logic [9:0] exp_st;
      for (int i = 0; i < 8; i++) begin
         tw = 1'b1; twd = 12'(i);
         tick();
         exp_st = {4'(i + 1), (i == 0), (i == 7), (i + 1 >= 6), (i + 1 <= 1), 1'b0, 1'b0};
         n_checks++;
         if (st !== exp_st)
            $display("FAIL fill_%0d: got %h expected %h", i, st, exp_st);
         else n_pass++;
      end
      twd = 12'h008;
      tick();
      tw = 1'b0;
      n_checks++;
      if ({st, rdv} !== {4'd8, 6'b011010, 12'h000})
         $display("FAIL fill_overflow: got %h expected %h", {st, rdv}, {4'd8, 6'b011010, 12'h000});
      else n_pass++;
      tr = 1'b1;
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if ({st[5], rdv} !== {1'b0, 12'(i)})
            $display("FAIL drain_%0d: got %h expected %h", i, {st[5], rdv}, {1'b0, 12'(i)});
         else n_pass++;
         tick();
      end
      tr = 1'b0;
      n_checks++;
      if (st !== {4'd0, 6'b100110})
         $display("FAIL drain_end: got %h expected %h", st, {4'd0, 6'b100110});
      else n_pass++;
      $display("test_fill: done");
   endtask

   task automatic test_underflow;
      tr = 1'b1;
      tick();
      tr = 1'b0;
      n_checks++;
      if (st !== {4'd0, 6'b100111})
         $display("FAIL underflow: got %h expected %h", st, {4'd0, 6'b100111});
      else n_pass++;
      $display("test_underflow: done");
   endtask

   task automatic test_flush;
      for (int i = 0; i < 5; i++) begin
         tw = 1'b1; twd = 12'(32'h020 + i);
         tick();
      end
      tw = 1'b0;
      tick();
      n_checks++;
      if ({st, rdv} !== {4'd5, 6'b000011, 12'h020})
         $display("FAIL flush_pre: got %h expected %h", {st, rdv}, {4'd5, 6'b000011, 12'h020});
      else n_pass++;
      tflush = 1'b1; tw = 1'b1; tr = 1'b1; twd = 12'hABC;
      tick();
      tflush = 1'b0; tw = 1'b0; tr = 1'b0;
      n_checks++;
      if ({st, rdv} !== {4'd0, 6'b100100, 12'h000})
         $display("FAIL flush_state: got %h expected %h", {st, rdv}, {4'd0, 6'b100100, 12'h000});
      else n_pass++;
      tw = 1'b1; twd = 12'h055;
      tick();
      tw = 1'b0;
      tick();
      n_checks++;
      if ({st, rdv} !== {4'd1, 6'b000100, 12'h055})
         $display("FAIL flush_after: got %h expected %h", {st, rdv}, {4'd1, 6'b000100, 12'h055});
      else n_pass++;
      tr = 1'b1;
      tick();
      tr = 1'b0;
      $display("test_flush: done");
   endtask

   task automatic test_back_to_back(input logic sel, input int depth);
      logic [9:0] exp_st;
      tsel = sel;
      for (int i = 0; i < 4; i++) begin
         tw = 1'b1; twd = 12'(32'h100 + i);
         tick();
      end
      tw = 1'b0;
      tick();
      exp_st = {4'd4, 1'b0, 1'b0, (4 >= depth - 2), 1'b0, 1'b0, 1'b0};
      tw = 1'b1; tr = 1'b1;
      for (int i = 0; i < 100; i++) begin
         twd = 12'(32'h104 + i);
         n_checks++;
         if ({st, rdv} !== {exp_st, 12'(32'h100 + i)})
            $display("FAIL stream_d%0d_%0d: got %h expected %h", depth, i,
                     {st, rdv}, {exp_st, 12'(32'h100 + i)});
         else n_pass++;
         tick();
      end
      tw = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if ({st[5], rdv} !== {1'b0, 12'(32'h164 + i)})
            $display("FAIL tail_d%0d_%0d: got %h expected %h", depth, i,
                     {st[5], rdv}, {1'b0, 12'(32'h164 + i)});
         else n_pass++;
         tick();
      end
      tr = 1'b0;
      n_checks++;
      if (st !== {4'd0, 6'b100100})
         $display("FAIL stream_end_d%0d: got %h expected %h", depth, st, {4'd0, 6'b100100});
      else n_pass++;
      tsel = 1'b0;
      #1;
      $display("test_back_to_back depth %0d: done", depth);
   endtask

   task automatic test_async_reset;
      for (int i = 0; i < 3; i++) begin
         tw = 1'b1; twd = 12'(32'h011 + i);
         tick();
      end
      tw = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({st, rdv} !== {4'd0, 6'b100100, 12'h000})
         $display("FAIL async_reset: got %h expected %h", {st, rdv}, {4'd0, 6'b100100, 12'h000});
      else n_pass++;
      #2;
      rst = 1'b0;
      tick();
      tw = 1'b1; twd = 12'h0AB;
      tick();
      tw = 1'b0;
      n_checks++;
      if ({st, rdv} !== {4'd1, 6'b100100, 12'h000})
         $display("FAIL post_reset_hidden: got %h expected %h", {st, rdv}, {4'd1, 6'b100100, 12'h000});
      else n_pass++;
      tick();
      n_checks++;
      if ({st, rdv} !== {4'd1, 6'b000100, 12'h0AB})
         $display("FAIL post_reset_visible: got %h expected %h", {st, rdv}, {4'd1, 6'b000100, 12'h0AB});
      else n_pass++;
      $display("test_async_reset: done");
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_fill();
      test_underflow();
      test_flush();
      test_back_to_back(1'b0, 8);
      test_back_to_back(1'b1, 6);
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
